// File: rtl/calib_readout_if.sv
// Bus bundle for calib_readout: calibration RAM read port plus the 8-bit
// valid/ready byte stream toward the host uplink.
// master = calib_readout side, slave = RAM / uplink side.
interface calib_readout_if;
   logic       calib_rden;
   logic       calib_rdbank;
   logic [9:0] calib_rdaddr;
   logic [7:0] calib_rddata;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output calib_rden, calib_rdbank, calib_rdaddr, tx_data, tx_valid,
      input  calib_rddata, tx_ready
   );

   modport slave (
      input  calib_rden, calib_rdbank, calib_rdaddr, tx_data, tx_valid,
      output calib_rddata, tx_ready
   );
endinterface

// File: rtl/calib_readout.sv
// calib_readout: reads a completed calibration bank byte by byte and frames
// it as SYNC(2) + LEN(2) + payload [+ checksum] on an 8-bit valid/ready
// stream. Only one RAM read is ever outstanding, so no data is discarded.
// Optional checksum byte: define CALIB_READOUT_CHECKSUM_EN.
module calib_readout #(
   parameter int          RAM_LATENCY = 1,
   parameter int          MAX_POINTS  = 64,
   parameter logic [15:0] SYNC_WORD   = 16'hA55A
) (
   input  logic            i_clk_50m,
   input  logic            i_rst,
   input  logic            i_read_en,
   input  logic            i_calib_make,
   input  logic            i_calib_pingpang,
   input  logic [15:0]     i_calib_points,
   calib_readout_if.master bus,
   output logic            o_busy,
   output logic            o_frame_done,
   output logic            o_make_drop
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      RD    = 3'd2,
      RWAIT = 3'd3,
      DATA  = 3'd4,
`ifdef CALIB_READOUT_CHECKSUM_EN
      CSUM  = 3'd5,
`endif
      DONE  = 3'd6
   } state_t;

   state_t      state;
   logic        rd_bank;
   logic [15:0] len;
   logic [1:0]  hdr_idx;
   logic [1:0]  lat_cnt;
   logic        rden;
   logic        rdbank;
   logic [9:0]  rdaddr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        frame_done;
   logic        make_drop;
   logic        hs;
   logic        last_byte;
   logic [15:0] clamp_len;
   logic [7:0]  hdr_next;

`ifdef CALIB_READOUT_CHECKSUM_EN
   logic [7:0]  sum;
   logic [7:0]  sum_next;
   // running sum including the byte currently on the bus
   assign sum_next = sum + tx_data;
`endif

   assign hs        = tx_valid & bus.tx_ready;
   assign last_byte = ({6'd0, rdaddr} == len - 16'd1);
   assign clamp_len = (i_calib_points > 16'(MAX_POINTS)) ? 16'(MAX_POINTS * 8)
                                                         : {i_calib_points[12:0], 3'b000};

   // header byte that follows the one currently being offered
   always_comb begin
      hdr_next = len[7:0];
      case (hdr_idx)
         2'd0:    hdr_next = SYNC_WORD[7:0];
         2'd1:    hdr_next = len[15:8];
         default: hdr_next = len[7:0];
      endcase
   end

   // frame FSM; every output is a register updated here
   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         state      <= IDLE;
         rd_bank    <= 1'b0;
         len        <= 16'd0;
         hdr_idx    <= 2'd0;
         lat_cnt    <= 2'd0;
         rden       <= 1'b0;
         rdbank     <= 1'b0;
         rdaddr     <= 10'd0;
         tx_data    <= 8'd0;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         make_drop  <= 1'b0;
`ifdef CALIB_READOUT_CHECKSUM_EN
         sum        <= 8'd0;
`endif
      end else begin
         frame_done <= 1'b0;
         rden       <= 1'b0;
         make_drop  <= i_calib_make & (state != IDLE);
         case (state)
            IDLE: if (i_calib_make && i_read_en) begin
               state    <= HDR;
               busy     <= 1'b1;
               rd_bank  <= ~i_calib_pingpang;
               len      <= clamp_len;
               hdr_idx  <= 2'd0;
               tx_data  <= SYNC_WORD[15:8];
               tx_valid <= 1'b1;
`ifdef CALIB_READOUT_CHECKSUM_EN
               sum      <= 8'd0;
`endif
            end
            HDR: if (hs) begin
`ifdef CALIB_READOUT_CHECKSUM_EN
               // length bytes are covered, sync bytes are not
               if (hdr_idx[1]) sum <= sum_next;
`endif
               hdr_idx <= hdr_idx + 2'd1;
               if (hdr_idx == 2'd3) begin
                  if (len == 16'd0) begin
`ifdef CALIB_READOUT_CHECKSUM_EN
                     state    <= CSUM;
                     tx_data  <= sum_next;
`else
                     state      <= DONE;
                     tx_valid   <= 1'b0;
                     frame_done <= 1'b1;
`endif
                  end else begin
                     state    <= RD;
                     rden     <= 1'b1;
                     rdaddr   <= 10'd0;
                     rdbank   <= rd_bank;
                     tx_valid <= 1'b0;
                  end
               end else begin
                  tx_data <= hdr_next;
               end
            end
            RD: begin
               state   <= RWAIT;
               lat_cnt <= 2'd0;
            end
            RWAIT: begin
               if (lat_cnt == 2'(RAM_LATENCY - 1)) begin
                  tx_data  <= bus.calib_rddata;
                  tx_valid <= 1'b1;
                  state    <= DATA;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            DATA: if (hs) begin
               if (last_byte) begin
`ifdef CALIB_READOUT_CHECKSUM_EN
                  state   <= CSUM;
                  tx_data <= sum_next;
`else
                  state      <= DONE;
                  tx_valid   <= 1'b0;
                  frame_done <= 1'b1;
`endif
               end else begin
`ifdef CALIB_READOUT_CHECKSUM_EN
                  sum      <= sum_next;
`endif
                  state    <= RD;
                  rden     <= 1'b1;
                  rdaddr   <= rdaddr + 10'd1;
                  rdbank   <= rd_bank;
                  tx_valid <= 1'b0;
               end
            end
`ifdef CALIB_READOUT_CHECKSUM_EN
            CSUM: if (hs) begin
               state      <= DONE;
               tx_valid   <= 1'b0;
               frame_done <= 1'b1;
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.calib_rden   = rden;
   assign bus.calib_rdbank = rdbank;
   assign bus.calib_rdaddr = rdaddr;
   assign bus.tx_data      = tx_data;
   assign bus.tx_valid     = tx_valid;
   assign o_busy           = busy;
   assign o_frame_done     = frame_done;
   assign o_make_drop      = make_drop;

endmodule

// File: tb/tb_calib_readout.sv
// Directed bench for calib_readout: three instances (RAM_LATENCY 1/2/3) share
// stimulus; instance 1 is checked in detail, 2 and 3 for latency and data.
module tb_calib_readout;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst, read_en, make, pingpang, tx_ready;
   logic [15:0] points;
   logic        busy1, busy2, busy3, fd1, fd2, fd3, drop1, drop2, drop3;

   calib_readout_if bus1 ();
   calib_readout_if bus2 ();
   calib_readout_if bus3 ();

   assign bus1.tx_ready = tx_ready;
   assign bus2.tx_ready = tx_ready;
   assign bus3.tx_ready = tx_ready;

   calib_readout #(.RAM_LATENCY(1)) dut1 (
      .i_clk_50m(clk), .i_rst(rst), .i_read_en(read_en), .i_calib_make(make),
      .i_calib_pingpang(pingpang), .i_calib_points(points), .bus(bus1),
      .o_busy(busy1), .o_frame_done(fd1), .o_make_drop(drop1));
   calib_readout #(.RAM_LATENCY(2)) dut2 (
      .i_clk_50m(clk), .i_rst(rst), .i_read_en(read_en), .i_calib_make(make),
      .i_calib_pingpang(pingpang), .i_calib_points(points), .bus(bus2),
      .o_busy(busy2), .o_frame_done(fd2), .o_make_drop(drop2));
   calib_readout #(.RAM_LATENCY(3)) dut3 (
      .i_clk_50m(clk), .i_rst(rst), .i_read_en(read_en), .i_calib_make(make),
      .i_calib_pingpang(pingpang), .i_calib_points(points), .bus(bus3),
      .o_busy(busy3), .o_frame_done(fd3), .o_make_drop(drop3));

   // RAM model: bank1 holds addr[7:0], bank0 holds ~addr[7:0]; data is
   // only present in the single cycle RAM_LATENCY clocks after the strobe
   function automatic logic [7:0] ram_byte(input logic bank, input logic [9:0] a);
      return bank ? a[7:0] : ~a[7:0];
   endfunction

   logic [7:0] p1;
   logic [7:0] p2 [2];
   logic [7:0] p3 [3];
   always @(posedge clk) begin
      p1    <= bus1.calib_rden ? ram_byte(bus1.calib_rdbank, bus1.calib_rdaddr) : 8'hEE;
      p2[0] <= bus2.calib_rden ? ram_byte(bus2.calib_rdbank, bus2.calib_rdaddr) : 8'hEE;
      p2[1] <= p2[0];
      p3[0] <= bus3.calib_rden ? ram_byte(bus3.calib_rdbank, bus3.calib_rdaddr) : 8'hEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bus1.calib_rddata = p1;
   assign bus2.calib_rddata = p2[1];
   assign bus3.calib_rddata = p3[2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor state
   int         cyc = 0;
   logic [7:0] q1[$], q2[$], q3[$], exp_q[$];
   int         hs_count, rden_cnt, bank_err, fd_cnt, fd_err, drop_cnt, stab_err;
   int         fd2_cnt, fd3_cnt, drop23_cnt, last_hs_cyc;
   int         gaps1, gaps2, gaps3, gerr1, gerr2, gerr3, rc1, rc2, rc3;
   bit         pend1, pend2, pend3;
   logic [9:0] last_addr;
   logic       exp_bank;
   logic       prev_v, prev_r;
   logic [7:0] prev_d;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus1.tx_valid && tx_ready) begin
         q1.push_back(bus1.tx_data);
         hs_count++;
         last_hs_cyc = cyc;
      end
      if (prev_v && !prev_r && (!bus1.tx_valid || bus1.tx_data != prev_d)) stab_err++;
      prev_v = bus1.tx_valid;
      prev_r = tx_ready;
      prev_d = bus1.tx_data;
      if (bus1.calib_rden) begin
         rden_cnt++;
         last_addr = bus1.calib_rdaddr;
         if (bus1.calib_rdbank != exp_bank) bank_err++;
         pend1 = 1'b1;
         rc1 = cyc;
      end else if (pend1 && bus1.tx_valid) begin
         pend1 = 1'b0;
         gaps1++;
         if (cyc - rc1 != 2) gerr1++;
      end
      if (fd1) begin
         fd_cnt++;
         if (cyc - last_hs_cyc != 1) fd_err++;
      end
      if (drop1) drop_cnt++;
      if (drop2 || drop3) drop23_cnt++;
      if (bus2.tx_valid && tx_ready) q2.push_back(bus2.tx_data);
      if (bus2.calib_rden) begin
         pend2 = 1'b1;
         rc2 = cyc;
      end else if (pend2 && bus2.tx_valid) begin
         pend2 = 1'b0;
         gaps2++;
         if (cyc - rc2 != 3) gerr2++;
      end
      if (fd2) fd2_cnt++;
      if (bus3.tx_valid && tx_ready) q3.push_back(bus3.tx_data);
      if (bus3.calib_rden) begin
         pend3 = 1'b1;
         rc3 = cyc;
      end else if (pend3 && bus3.tx_valid) begin
         pend3 = 1'b0;
         gaps3++;
         if (cyc - rc3 != 4) gerr3++;
      end
      if (fd3) fd3_cnt++;
   end

   // ready driver: mode 0 = always ready, mode 1 = toggle plus a 5-cycle
   // stall while payload byte 3 of instance 1 is on offer
   int rdy_mode   = 0;
   int stall_left = 0;
   bit stalled_done;
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) tx_ready = 1'b1;
      else if (stall_left > 0) begin
         tx_ready = 1'b0;
         stall_left--;
      end else if (!stalled_done && hs_count == 7 && bus1.tx_valid) begin
         tx_ready     = 1'b0;
         stall_left   = 4;
         stalled_done = 1'b1;
      end else tx_ready = ~tx_ready;
   end

   task automatic clr_mon();
      q1.delete(); q2.delete(); q3.delete(); exp_q.delete();
      hs_count = 0; rden_cnt = 0; bank_err = 0; fd_cnt = 0; fd_err = 0;
      drop_cnt = 0; stab_err = 0; fd2_cnt = 0; fd3_cnt = 0; drop23_cnt = 0;
      gaps1 = 0; gaps2 = 0; gaps3 = 0; gerr1 = 0; gerr2 = 0; gerr3 = 0;
      pend1 = 1'b0; pend2 = 1'b0; pend3 = 1'b0;
      stalled_done = 1'b0; stall_left = 0; last_addr = 10'd0;
   endtask

   // append the expected frame for a make with (pts, pp) to exp_q
   task automatic add_exp(input int pts, input logic pp);
      int n, ln;
      logic [7:0] s, b;
      n  = (pts > 64) ? 64 : pts;
      ln = n * 8;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(ln[15:8]);
      exp_q.push_back(ln[7:0]);
      s = ln[15:8] + ln[7:0];
      for (int a = 0; a < ln; a++) begin
         b = pp ? ~a[7:0] : a[7:0];
         exp_q.push_back(b);
         s = s + b;
      end
`ifdef CALIB_READOUT_CHECKSUM_EN
      exp_q.push_back(s);
`endif
   endtask

   task automatic cmp_stream(input string tag, input logic [7:0] got[$]);
      int errs = 0;
      chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) errs++;
      chk({tag, "_bytes"}, 32'(errs), 32'd0);
   endtask

   task automatic start_frame(input logic pp, input int pts, input string tag);
      @(posedge clk); #1;
      make = 1'b1; pingpang = pp; points = 16'(pts);
      @(posedge clk); #1;
      make = 1'b0;
      @(negedge clk);
      chk({tag, "_first"}, 32'({bus1.tx_valid, bus1.tx_data}), 32'({1'b1, 8'hA5}));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy1 || busy2 || busy3) && n < 8000);
      chk({tag, "_idle"}, 32'(busy1 | busy2 | busy3), 32'd0);
   endtask

   function automatic logic [31:0] outs1();
      return 32'({busy1, fd1, drop1, bus1.calib_rden, bus1.calib_rdbank,
                  bus1.calib_rdaddr, bus1.tx_valid, bus1.tx_data});
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      int n, r, h;
      rst = 1'b1; read_en = 1'b1; make = 1'b0; pingpang = 1'b0;
      points = 16'd0; tx_ready = 1'b1; exp_bank = 1'b1;
      prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'd0;
      clr_mon();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", outs1(), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // enable low: make is ignored silently
      @(posedge clk); #1;
      read_en = 1'b0; make = 1'b1; points = 16'd2;
      @(posedge clk); #1 make = 1'b0;
      @(negedge clk);
      chk("noen_busy", 32'(busy1), 32'd0);
      chk("noen_drop", 32'(drop1), 32'd0);
      read_en = 1'b1;

      // basic frame, all three latencies
      clr_mon(); exp_bank = 1'b1; add_exp(2, 1'b0);
      start_frame(1'b0, 2, "basic");
      wait_idle("basic");
      cmp_stream("basic", q1);
      cmp_stream("lat2", q2);
      cmp_stream("lat3", q3);
      chk("basic_rden_cnt", 32'(rden_cnt), 32'd16);
      chk("basic_bank_err", 32'(bank_err), 32'd0);
      chk("basic_fd_cnt", 32'(fd_cnt), 32'd1);
      chk("basic_fd_timing", 32'(fd_err), 32'd0);
      chk("lat1_gaps", 32'(gaps1), 32'd16);
      chk("lat1_gap_err", 32'(gerr1), 32'd0);
      chk("lat2_gaps", 32'(gaps2), 32'd16);
      chk("lat2_gap_err", 32'(gerr2), 32'd0);
      chk("lat3_gaps", 32'(gaps3), 32'd16);
      chk("lat3_gap_err", 32'(gerr3), 32'd0);
      chk("lat23_fd_cnt", 32'(fd2_cnt + fd3_cnt), 32'd2);

      // backpressure
      clr_mon(); rdy_mode = 1; add_exp(2, 1'b0);
      start_frame(1'b0, 2, "bp");
      wait_idle("bp");
      rdy_mode = 0;
      cmp_stream("bp", q1);
      chk("bp_stable", 32'(stab_err), 32'd0);
      chk("bp_stall_hit", 32'(stalled_done), 32'd1);
      chk("bp_rden_cnt", 32'(rden_cnt), 32'd16);
      chk("bp_fd_cnt", 32'(fd_cnt), 32'd1);
      chk("bp_fd_timing", 32'(fd_err), 32'd0);

      // clamp: 100 points -> 64 records, bank 0
      clr_mon(); exp_bank = 1'b0; add_exp(100, 1'b1);
      start_frame(1'b1, 100, "clamp");
      wait_idle("clamp");
      cmp_stream("clamp", q1);
      chk("clamp_len_hi", 32'(q1[2]), 32'h02);
      chk("clamp_rden_cnt", 32'(rden_cnt), 32'd512);
      chk("clamp_last_addr", 32'(last_addr), 32'd511);
      chk("clamp_bank_err", 32'(bank_err), 32'd0);

      // zero points
      clr_mon(); exp_bank = 1'b1; add_exp(0, 1'b0);
      start_frame(1'b0, 0, "zero");
      wait_idle("zero");
      cmp_stream("zero", q1);
      chk("zero_rden_cnt", 32'(rden_cnt), 32'd0);
      chk("zero_fd_cnt", 32'(fd_cnt), 32'd1);

      // collision: make mid-frame dropped, make right after done accepted
      clr_mon(); add_exp(2, 1'b0); add_exp(1, 1'b1);
      start_frame(1'b0, 2, "coll");
      repeat (10) @(posedge clk);
      #1 make = 1'b1; pingpang = 1'b1; points = 16'd5;
      @(posedge clk); #1 make = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fd1 && n < 2000);
      chk("coll_fd_seen", 32'(fd1), 32'd1);
      @(posedge clk); #1;
      make = 1'b1; pingpang = 1'b1; points = 16'd1;
      @(posedge clk); #1 make = 1'b0;
      @(negedge clk);
      chk("coll_restart", 32'({bus1.tx_valid, bus1.tx_data}), 32'({1'b1, 8'hA5}));
      wait_idle("coll");
      cmp_stream("coll", q1);
      chk("coll_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("coll_fd_cnt", 32'(fd_cnt), 32'd2);

      // reset during payload byte 5
      clr_mon(); exp_bank = 1'b1;
      start_frame(1'b0, 2, "rst_pre");
      n = 0;
      while (hs_count < 9 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach", 32'(hs_count >= 9), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_outs", outs1(), 32'd0);
      r = rden_cnt;
      h = hs_count;
      repeat (10) @(negedge clk);
      chk("rst_quiet_rd", 32'(rden_cnt), 32'(r));
      chk("rst_quiet_tx", 32'(hs_count), 32'(h));
      clr_mon(); add_exp(2, 1'b0);
      start_frame(1'b0, 2, "rst_post");
      wait_idle("rst_post");
      cmp_stream("rst_post", q1);
      chk("rst_post_fd_cnt", 32'(fd_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
